// File: rtl/sprite_compositor.sv
// N-layer sprite/background/full-screen compositor with colour-key transparency, frame-synced mode and per-frame player collisions.
// Two-cycle coordinate-to-pixel latency at one pixel per clock; there is no backpressure and the pixel stream never stalls.
module sprite_compositor #(
    parameter int          N_LAYERS   = 8,
    parameter int          XW         = 11,
    parameter int          YW         = 10,
    parameter int          SPR_W      = 32,
    parameter int          SPR_H      = 32,
    parameter logic [11:0] KEY_RGB    = 12'h000,
    parameter int          XMIN       = 10,
    parameter int          XMAX       = 1268,
    parameter int          YMIN       = 10,
    parameter int          YMAX       = 789,
    parameter logic [11:0] BORDER_RGB = 12'h078
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [XW-1:0]          draw_x,
    input  logic [YW-1:0]          draw_y,
    input  logic                   pix_valid,
    input  logic                   start,
    input  logic                   win,
    input  logic                   lose,
    input  logic [N_LAYERS*XW-1:0] lyr_x,
    input  logic [N_LAYERS*YW-1:0] lyr_y,
    input  logic [N_LAYERS-1:0]    lyr_en,
    input  logic [N_LAYERS*12-1:0] lyr_rgb,
    input  logic [11:0]            bg_rgb,
    input  logic [11:0]            screen_rgb,
    input  logic                   screen_on,
    output logic [3:0]             draw_r,
    output logic [3:0]             draw_g,
    output logic [3:0]             draw_b,
    output logic [1:0]             mode,
    output logic [N_LAYERS-1:0]    collide,
    output logic                   frame_done
);

    typedef enum logic [1:0] {
        MODE_TITLE = 2'd0,
        MODE_PLAY  = 2'd1,
        MODE_WIN   = 2'd2,
        MODE_LOSE  = 2'd3
    } mode_e;

    mode_e                mode_q, mode_d, req_mode;
    logic                 frame_start;
    logic [N_LAYERS-1:0]  hit_d, hit_q;
    logic                 border_d, border_q;
    logic                 vld1_d, vld1_q;
    logic                 fs1_d, fs1_q;
    logic [N_LAYERS-1:0]  opaque;
    logic                 layer_hit;
    logic [11:0]          layer_rgb;
    logic [11:0]          rgb_d, rgb_q;
    logic [N_LAYERS-1:0]  pair_hit;
    logic [N_LAYERS-1:0]  acc_d, acc_q;
    logic [N_LAYERS-1:0]  collide_d, collide_q;
    logic                 frame_done_d, frame_done_q;

    // Stage 0: frame-start detection, mode FSM next state, border flag.
    always_comb begin
        frame_start = pix_valid && (draw_x == '0) && (draw_y == '0);
        if (!start)
            req_mode = MODE_TITLE;
        else if (win)
            req_mode = MODE_WIN;
        else if (lose)
            req_mode = MODE_LOSE;
        else
            req_mode = MODE_PLAY;
        mode_d = mode_q;
        if (frame_start)
            mode_d = req_mode;
        border_d = (draw_x <= XW'(XMIN)) || (draw_x >= XW'(XMAX)) ||
                   (draw_y <= YW'(YMIN)) || (draw_y >= YW'(YMAX));
        vld1_d = pix_valid;
        fs1_d  = frame_start;
    end

    // Box ends are widened by one bit so a sprite near the right/bottom edge clips instead of wrapping.
    for (genvar gi = 0; gi < N_LAYERS; gi++) begin : g_layer
        logic [XW:0] x_lo, x_hi;
        logic [YW:0] y_lo, y_hi;
        assign x_lo = {1'b0, lyr_x[gi*XW +: XW]};
        assign x_hi = x_lo + (XW+1)'(SPR_W);
        assign y_lo = {1'b0, lyr_y[gi*YW +: YW]};
        assign y_hi = y_lo + (YW+1)'(SPR_H);
        assign hit_d[gi] = lyr_en[gi] &&
                           ({1'b0, draw_x} >= x_lo) && ({1'b0, draw_x} < x_hi) &&
                           ({1'b0, draw_y} >= y_lo) && ({1'b0, draw_y} < y_hi);
        assign opaque[gi] = hit_q[gi] && (lyr_rgb[gi*12 +: 12] != KEY_RGB);
    end

    // Stage 1: colour selection and collision accumulation, aligned with the ROM colours.
    always_comb begin
        layer_hit = 1'b0;
        layer_rgb = bg_rgb;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                layer_hit = 1'b1;
                layer_rgb = lyr_rgb[i*12 +: 12];
            end
        end

        rgb_d = 12'h000;
        if (vld1_q) begin
            if (mode_q == MODE_PLAY) begin
                if (layer_hit)
                    rgb_d = layer_rgb;
                else if (border_q)
                    rgb_d = BORDER_RGB;
                else
                    rgb_d = bg_rgb;
            end else if (screen_on && (screen_rgb != KEY_RGB)) begin
                rgb_d = screen_rgb;
            end else if (border_q) begin
                rgb_d = BORDER_RGB;
            end else if (mode_q == MODE_LOSE) begin
                rgb_d = 12'h000;
            end else begin
                rgb_d = 12'hFFF;
            end
        end

        pair_hit = '0;
        if (vld1_q && (mode_q == MODE_PLAY) && opaque[0])
            pair_hit = opaque;
        pair_hit[0] = 1'b0;

        // The frame-start pixel's own hits close out the old frame rather than open the new one.
        acc_d        = acc_q | pair_hit;
        collide_d    = collide_q;
        frame_done_d = 1'b0;
        if (fs1_q) begin
            collide_d    = acc_q | pair_hit;
            acc_d        = '0;
            frame_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q       <= MODE_TITLE;
            hit_q        <= '0;
            border_q     <= 1'b0;
            vld1_q       <= 1'b0;
            fs1_q        <= 1'b0;
            rgb_q        <= 12'h000;
            acc_q        <= '0;
            collide_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            hit_q        <= hit_d;
            border_q     <= border_d;
            vld1_q       <= vld1_d;
            fs1_q        <= fs1_d;
            rgb_q        <= rgb_d;
            acc_q        <= acc_d;
            collide_q    <= collide_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign draw_r     = rgb_q[11:8];
    assign draw_g     = rgb_q[7:4];
    assign draw_b     = rgb_q[3:0];
    assign mode       = mode_q;
    assign collide    = collide_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: directed scenes with literal expectations, then randomized pixels against a behavioural model.
module tb_sprite_compositor;
    localparam int N  = 8;
    localparam int XW = 11;
    localparam int YW = 10;
    localparam int SW = 32;
    localparam int SH = 32;
    localparam logic [11:0] BORDER = 12'h078;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [XW-1:0]   draw_x;
    logic [YW-1:0]   draw_y;
    logic            pix_valid, start, win, lose;
    logic [N*XW-1:0] lyr_x;
    logic [N*YW-1:0] lyr_y;
    logic [N-1:0]    lyr_en;
    logic [N*12-1:0] lyr_rgb;
    logic [11:0]     bg_rgb, screen_rgb;
    logic            screen_on;
    logic [3:0]      draw_r, draw_g, draw_b;
    logic [1:0]      mode;
    logic [N-1:0]    collide;
    logic            frame_done;

    sprite_compositor dut (
        .clk(clk), .rst(rst), .draw_x(draw_x), .draw_y(draw_y), .pix_valid(pix_valid),
        .start(start), .win(win), .lose(lose), .lyr_x(lyr_x), .lyr_y(lyr_y), .lyr_en(lyr_en),
        .lyr_rgb(lyr_rgb), .bg_rgb(bg_rgb), .screen_rgb(screen_rgb), .screen_on(screen_on),
        .draw_r(draw_r), .draw_g(draw_g), .draw_b(draw_b), .mode(mode),
        .collide(collide), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Scene and per-pixel colour choices; colours reach the DUT one cycle after their coordinate.
    int              lx[N], ly[N];
    bit              en[N];
    logic [11:0]     nc[N];
    logic [11:0]     n_bg, n_scr;
    logic            n_on;
    logic [N*12-1:0] pend_rgb;
    logic [11:0]     pend_bg, pend_scr;
    logic            pend_on;

    int              mode_m;
    logic [N-1:0]    acc_m, coll_m;
    logic [11:0]     exp_rgb[8];
    logic [1:0]      exp_mode[8];
    logic [N-1:0]    exp_coll[8];
    logic            exp_fd[8];
    logic [11:0]     last_c;
    int              cyc = 0;
    bit              chk_on = 1'b0;
    int              n_chk = 0;
    int              n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("pixel", 32'({draw_r, draw_g, draw_b}), 32'(exp_rgb[cyc % 8]));
            check("mode", 32'(mode), 32'(exp_mode[cyc % 8]));
            check("collide", 32'(collide), 32'(exp_coll[cyc % 8]));
            check("frame_done", 32'(frame_done), 32'(exp_fd[cyc % 8]));
        end
    end

    // Drive one coordinate for one cycle and predict what it must produce.
    task automatic pixel(input int x, input int y, input bit v);
        bit           fs, border;
        int           req, k;
        logic [N-1:0] op, hits;
        logic [11:0]  c;
        bit           fd;
        draw_x    = XW'(x);
        draw_y    = YW'(y);
        pix_valid = v;
        for (int i = 0; i < N; i++) begin
            lyr_x[i*XW +: XW] = XW'(lx[i]);
            lyr_y[i*YW +: YW] = YW'(ly[i]);
            lyr_en[i]         = en[i];
        end
        lyr_rgb    = pend_rgb;
        bg_rgb     = pend_bg;
        screen_rgb = pend_scr;
        screen_on  = pend_on;

        fs  = v && (x == 0) && (y == 0);
        req = !start ? 0 : win ? 2 : lose ? 3 : 1;
        if (fs) mode_m = req;
        k = -1;
        for (int i = N - 1; i >= 0; i--) begin
            op[i] = en[i] && (x >= lx[i]) && (x < lx[i] + SW) && (y >= ly[i]) && (y < ly[i] + SH) &&
                    (nc[i] != 12'h000);
            if (op[i]) k = i;
        end
        border = (x <= 10) || (x >= 1268) || (y <= 10) || (y >= 789);
        if (!v)
            c = 12'h000;
        else if (mode_m == 1) begin
            if (k >= 0) c = nc[k];
            else if (border) c = BORDER;
            else c = n_bg;
        end else if (n_on && n_scr != 12'h000)
            c = n_scr;
        else if (border)
            c = BORDER;
        else
            c = (mode_m == 3) ? 12'h000 : 12'hFFF;

        hits = '0;
        if (v && mode_m == 1 && op[0]) begin
            hits    = op;
            hits[0] = 1'b0;
        end
        if (fs) begin
            coll_m = acc_m | hits;
            acc_m  = '0;
            fd     = 1'b1;
        end else begin
            acc_m = acc_m | hits;
            fd    = 1'b0;
        end
        last_c                  = c;
        exp_rgb[(cyc + 2) % 8]  = c;
        exp_coll[(cyc + 2) % 8] = coll_m;
        exp_fd[(cyc + 2) % 8]   = fd;
        exp_mode[(cyc + 1) % 8] = 2'(mode_m);

        for (int i = 0; i < N; i++) pend_rgb[i*12 +: 12] = nc[i];
        pend_bg  = n_bg;
        pend_scr = n_scr;
        pend_on  = n_on;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        rst    = 1'b1;
        mode_m = 0;
        acc_m  = '0;
        coll_m = '0;
        #1;
        check("rst_async_pixel", 32'({draw_r, draw_g, draw_b}), 32'(0));
        check("rst_async_mode", 32'(mode), 32'(0));
        for (int j = 0; j < n; j++) begin
            for (int d = 0; d < 3; d++) begin
                exp_rgb[(cyc + d) % 8]  = 12'h000;
                exp_coll[(cyc + d) % 8] = '0;
                exp_fd[(cyc + d) % 8]   = 1'b0;
            end
            exp_mode[cyc % 8]       = 2'd0;
            exp_mode[(cyc + 1) % 8] = 2'd0;
            @(posedge clk);
            #1;
            cyc++;
        end
        rst = 1'b0;
    endtask

    // Two cycles: the coordinate, then an invalid filler so the result is visible.
    task automatic px_chk(input string name, input int x, input int y, input logic [11:0] want);
        pixel(x, y, 1'b1);
        check({name, "_model"}, 32'(last_c), 32'(want));
        pixel(1, 1, 1'b0);
        check(name, 32'({draw_r, draw_g, draw_b}), 32'(want));
    endtask

    task automatic scramble();
        for (int i = 0; i < N; i++) begin
            en[i] = ($urandom_range(0, 3) != 0);
            lx[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2000, 2047)) : int'($urandom_range(0, 400));
            ly[i] = int'($urandom_range(0, 400));
        end
    endtask

    initial begin
        int r, x, y, li;
        draw_x = '0; draw_y = '0; pix_valid = 1'b0; start = 1'b0; win = 1'b0; lose = 1'b0;
        lyr_x = '0; lyr_y = '0; lyr_en = '0; lyr_rgb = '0; bg_rgb = '0; screen_rgb = '0; screen_on = 1'b0;
        for (int i = 0; i < N; i++) begin
            lx[i] = 0; ly[i] = 0; en[i] = 1'b0; nc[i] = 12'h000;
        end
        n_bg = 12'h123; n_scr = 12'h000; n_on = 1'b0;
        pend_rgb = '0; pend_bg = '0; pend_scr = '0; pend_on = 1'b0;
        mode_m = 0; acc_m = '0; coll_m = '0;
        for (int d = 0; d < 8; d++) begin
            exp_rgb[d] = '0; exp_mode[d] = '0; exp_coll[d] = '0; exp_fd[d] = 1'b0;
        end
        @(posedge clk);
        #1;
        chk_on = 1'b1;
        do_reset(3);
        check("reset_mode", 32'(mode), 32'(0));
        check("reset_collide", 32'(collide), 32'(0));
        check("reset_frame_done", 32'(frame_done), 32'(0));

        // Priority and transparency
        start = 1'b1;
        pixel(0, 0, 1'b1);
        check("mode_play", 32'(mode), 32'(1));
        en[0] = 1'b1; lx[0] = 100; ly[0] = 100; nc[0] = 12'hA5C;
        en[3] = 1'b1; lx[3] = 100; ly[3] = 100; nc[3] = 12'h3B1;
        px_chk("priority", 105, 105, 12'hA5C);
        nc[0] = 12'h000;
        px_chk("key_transparent", 105, 105, 12'h3B1);
        en[3] = 1'b0;
        px_chk("key_to_bg", 105, 105, 12'h123);

        // Box edges and clipping
        en[0] = 1'b0; en[1] = 1'b1; lx[1] = 200; ly[1] = 100; nc[1] = 12'h9E7;
        px_chk("box_left", 200, 110, 12'h9E7);
        px_chk("box_left_out", 199, 110, 12'h123);
        px_chk("box_right_in", 231, 110, 12'h9E7);
        px_chk("box_right_out", 232, 110, 12'h123);
        px_chk("box_bottom_in", 210, 131, 12'h9E7);
        px_chk("box_bottom_out", 210, 132, 12'h123);
        lx[1] = 2040;
        for (int i = 0; i < 8; i++) px_chk("clip_no_alias", i, 110, BORDER);
        px_chk("clip_edge", 2047, 110, 12'h9E7);

        // Frame-synchronous mode changes
        win = 1'b1;
        pixel(600, 300, 1'b1);
        check("mode_defer", 32'(mode), 32'(1));
        px_chk("defer_play_pixel", 650, 300, 12'h123);
        pixel(0, 0, 1'b1);
        check("mode_win", 32'(mode), 32'(2));
        px_chk("win_fill", 500, 500, 12'hFFF);
        n_on = 1'b1; n_scr = 12'h456;
        px_chk("win_screen", 500, 500, 12'h456);
        n_scr = 12'h000;
        px_chk("win_screen_key", 5, 500, BORDER);
        lose = 1'b1;
        pixel(0, 0, 1'b1);
        check("mode_win_over_lose", 32'(mode), 32'(2));
        win = 1'b0;
        pixel(0, 0, 1'b1);
        check("mode_lose", 32'(mode), 32'(3));
        n_on = 1'b0; en[0] = 1'b1; lx[0] = 490; ly[0] = 490; nc[0] = 12'hF00;
        px_chk("lose_fill", 500, 500, 12'h000);

        // Collision report
        lose = 1'b0;
        for (int i = 0; i < N; i++) en[i] = 1'b0;
        pixel(0, 0, 1'b1);
        check("mode_play_again", 32'(mode), 32'(1));
        en[0] = 1'b1; lx[0] = 100; ly[0] = 100; nc[0] = 12'hF00;
        en[5] = 1'b1; lx[5] = 110; ly[5] = 110; nc[5] = 12'h0F0;
        pixel(115, 115, 1'b1);
        pixel(300, 300, 1'b1);
        pixel(0, 0, 1'b1);
        check("fd_not_early", 32'(frame_done), 32'(0));
        pixel(1, 1, 1'b0);
        check("collide_l5", 32'(collide), 32'(8'b0010_0000));
        check("fd_pulse", 32'(frame_done), 32'(1));
        pixel(1, 1, 1'b0);
        check("fd_single", 32'(frame_done), 32'(0));
        pixel(0, 0, 1'b1);
        pixel(1, 1, 1'b0);
        check("collide_clear", 32'(collide), 32'(0));
        check("fd_pulse2", 32'(frame_done), 32'(1));

        // Reset in mid-frame while in WIN
        win = 1'b1;
        pixel(0, 0, 1'b1);
        pixel(300, 300, 1'b1);
        check("mode_win_pre_rst", 32'(mode), 32'(2));
        do_reset(2);
        win = 1'b0;
        pixel(115, 115, 1'b1);
        pixel(116, 116, 1'b1);
        pixel(1, 1, 1'b0);
        check("collide_after_rst", 32'(collide), 32'(0));
        check("mode_after_rst", 32'(mode), 32'(0));
        pixel(0, 0, 1'b1);
        pixel(1, 1, 1'b0);
        check("fd_first_frame", 32'(frame_done), 32'(1));
        check("collide_first_frame", 32'(collide), 32'(0));

        // Randomized traffic
        scramble();
        for (int t = 0; t < 6000; t++) begin
            if ($urandom_range(0, 199) == 0) scramble();
            if ($urandom_range(0, 299) == 0) begin
                start = ($urandom_range(0, 6) != 0);
                win   = ($urandom_range(0, 4) == 0);
                lose  = ($urandom_range(0, 4) == 0);
            end
            for (int i = 0; i < N; i++) nc[i] = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
            n_bg  = 12'($urandom);
            n_scr = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
            n_on  = ($urandom_range(0, 1) != 0);
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                x = 0; y = 0;
            end else if (r < 60) begin
                li = int'($urandom_range(0, N - 1));
                x = lx[li] + int'($urandom_range(0, SW + 3)) - 2;
                y = ly[li] + int'($urandom_range(0, SH + 3)) - 2;
            end else if (r < 70) begin
                x = int'($urandom_range(0, 12)); y = int'($urandom_range(0, 1023));
            end else if (r < 75) begin
                x = int'($urandom_range(1265, 1270)); y = int'($urandom_range(785, 792));
            end else begin
                x = int'($urandom_range(0, 2047)); y = int'($urandom_range(0, 1023));
            end
            if (x < 0) x = 0;
            if (x > 2047) x = 2047;
            if (y < 0) y = 0;
            if (y > 1023) y = 1023;
            if ($urandom_range(0, 2499) == 0)
                do_reset(int'($urandom_range(1, 2)));
            else
                pixel(x, y, $urandom_range(0, 7) != 0);
        end

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised pixel compositor for the VGA path: merges N sprite layers, a background colour and a full-screen title/win/lose image into one 12-bit pixel per draw coordinate. It is the pipelined, N-layer successor to the fixed-layer combinational drawing logic. It adds colour-key transparency, frame-synchronous screen-mode switching and a per-frame player-collision report. It sits between the sprite ROM display modules and the VGA timing output.

## Interface

**Parameters**
- `N_LAYERS`, default 8: number of sprite layers. Layer 0 is the player, which has the highest priority.
- `XW`, default 11: width of `draw_x` and layer x positions.
- `YW`, default 10: width of `draw_y` and layer y positions.
- `SPR_W`, default 32: sprite width in pixels.
- `SPR_H`, default 32: sprite height in pixels.
- `KEY_RGB`, default 12'h000: transparent colour key.
- `XMIN` 10, `XMAX` 1268, `YMIN` 10, `YMAX` 789: border limits.
- `BORDER_RGB`, default 12'h078: border colour.

**Ports**
- `clk`, in, 1: pixel clock.
- `rst`, in, 1: reset. Asynchronous, active-high.
- `draw_x`, in, `XW`: current x coordinate.
- `draw_y`, in, `YW`: current y coordinate.
- `pix_valid`, in, 1: active-video qualifier for `draw_x`/`draw_y`.
- `start`, in, 1: game started (level).
- `win`, in, 1: game won (level).
- `lose`, in, 1: game lost (level).
- `lyr_x`, in, `N_LAYERS*XW`: packed layer x positions; layer i occupies slice [i*XW +: XW].
- `lyr_y`, in, `N_LAYERS*YW`: packed layer y positions.
- `lyr_en`, in, `N_LAYERS`: layer enables. Replaces the old disappear flags.
- `lyr_rgb`, in, `N_LAYERS*12`: sprite ROM colours. Valid one cycle after the matching coordinate.
- `bg_rgb`, in, 12: play-mode background colour.
- `screen_rgb`, in, 12: colour of the active full-screen image. One-cycle latency.
- `screen_on`, in, 1: full-screen image covers this pixel. Aligned with `screen_rgb`.
- `draw_r`, out, 4: output red.
- `draw_g`, out, 4: output green.
- `draw_b`, out, 4: output blue.
- `mode`, out, 2: current mode. 0 TITLE, 1 PLAY, 2 WIN, 3 LOSE.
- `collide`, out, `N_LAYERS`: bit i is set if the player overlapped layer i in the last completed frame. Bit 0 is always 0.
- `frame_done`, out, 1: one-cycle pulse when `collide` updates.

## Operation

**Requested mode**
- `!start` → TITLE.
- `start && win` → WIN. Win has precedence over lose.
- `start && !win && lose` → LOSE.
- Otherwise → PLAY.

**Mode FSM**
- Any state can move to any state.
- `mode` loads the requested mode only on a frame-start event: stage 0 sees `pix_valid && draw_x==0 && draw_y==0`.
- Mode changes in mid-frame are deferred to the next frame start. The screen never tears.

**Hit test (per layer i)**
- Condition: `lyr_en[i]`, `draw_x >= x_i`, `draw_x < x_i+SPR_W`, `draw_y >= y_i` and `draw_y < y_i+SPR_H`.
- The box is half-open, exactly SPR_W×SPR_H.
- Sums are computed at XW+1 / YW+1 bits, so there is no wrap-around. A sprite at x = 2^XW−SPR_W or beyond is clipped, never aliased to x = 0.

**Opacity and border**
- Layer i is opaque at a pixel when it hits and `lyr_rgb_i != KEY_RGB`.
- Border region: `draw_x<=XMIN`, `draw_x>=XMAX`, `draw_y<=YMIN` or `draw_y>=YMAX`.

**Pixel selection in PLAY**, in priority order:
1. The lowest-index opaque layer.
2. Otherwise `BORDER_RGB` in the border region.
3. Otherwise `bg_rgb`.

**Pixel selection in TITLE / WIN / LOSE** (layers are ignored), in priority order:
1. `screen_rgb` if `screen_on` and it is not `KEY_RGB`.
2. Otherwise `BORDER_RGB` in the border region.
3. Otherwise fill: 12'hFFF for TITLE and WIN, 12'h000 for LOSE.

**Invalid pixels**
- When `pix_valid` is low, the output is 12'h000.

**Collision accumulation**
- Runs in PLAY, on valid pixels, at the stage where layer colours are valid.
- If layer 0 is opaque and layer i (i ≥ 1) is opaque, set `acc[i]`.
- On the frame-start event: `collide <= acc | this-cycle hits`, `acc <= 0`, `frame_done <= 1` for one cycle.
- A pixel being accumulated in the same cycle as the clear is folded into `collide`, never lost and never carried into the new frame.

## Timing

**Pipeline**
- Stage 0: coordinates arrive.
- Stage 1 register: hit mask, border flag, valid, frame-start flag. Aligned with `lyr_rgb`, `screen_rgb` and `screen_on`.
- Stage 2 register: selected colour, driven onto `draw_r/g/b`.
- Latency is exactly 2 cycles from coordinate to `draw_*`, with a throughput of one pixel per clock.
- `mode` updates 1 cycle after the frame-start coordinate.
- `collide` and `frame_done` update 2 cycles after the frame-start coordinate.
- The mode used for a pixel is the `mode` register value at stage 1. The frame-start pixel itself is therefore drawn in the new mode.

**Reset** (`rst` asserted, takes effect asynchronously)
- `draw_r/g/b` = 0.
- `mode` = TITLE.
- `collide` = 0, `frame_done` = 0.
- `acc` = 0, all pipeline valids = 0.
- Reset in mid-frame discards in-flight pixels. The first `frame_done` comes at the first frame start after release.

## Test plan

- **Priority:** PLAY; layers 0 and 3 both at (100,100) and opaque. → The pixel at (105,105) equals `lyr_rgb_0`, two cycles after the coordinate.
- **Transparency:** layer 0 at (100,100) has `lyr_rgb_0`=12'h000; layer 3 is opaque. → Output is `lyr_rgb_3`. With layer 3 disabled, output is `bg_rgb`.
- **Box edges and clipping:** sprite at x=200 shows at 231 but not at 232. Sprite at x=2040 never shows at x=0..7.
- **Frame-synced mode:** `win` rises at (600,300). → Rest of the frame stays PLAY; `mode`=2 one cycle after (0,0). Win and lose together → WIN. Off-sprite pixels in LOSE are 12'h000.
- **Collision:** player overlaps layer 5 during one frame. → At the next frame start, `collide`=8'b0010_0000 and `frame_done` pulses once. With no overlap in the following frame, `collide`=0.
- **Reset:** assert `rst` mid-frame while in WIN. → Outputs are 0 and `mode`=0 immediately. After release, `collide` stays 0 until the first frame start.
